// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler: HI/LO unit sequencer for the EX stage.
// Issues multiply/divide start pulses, tracks the outstanding op, stalls
// dependent HI/LO instructions, and owns the architectural HI/LO registers.
module muldiv_scheduler #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall_out,
    output logic [31:0] mf_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_start,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_abort,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam logic [3:0] OP_MTHI = 4'd8;
    localparam logic [3:0] OP_MTLO = 4'd9;
    localparam logic [3:0] OP_MFHI = 4'd10;
    localparam logic [3:0] OP_MFLO = 4'd11;
    localparam logic [3:0] LAT     = 4'(MUL_LAT);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

    state_t      r_state;
    acc_t        r_acc;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_valid_code;
    logic        w_idle;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_mul_done;
    logic [63:0] w_hilo;
    logic [63:0] w_hilo_next;

    // Decode: 0,1 MULT(U); 2,3 DIV(U); 4-7 MADD/MSUB; 12-15 are not HI/LO ops.
    assign w_valid_code = (op_code < 4'd12);
    assign w_is_mul     = (op_code[3:1] == 3'b000) | (op_code[3:2] == 2'b01);
    assign w_is_div     = (op_code[3:1] == 3'b001);
    assign w_idle       = (r_state == S_IDLE);
    // Reset gates every combinational request so nothing leaks out in the reset cycle.
    assign w_accept     = rst & op_valid & w_valid_code & w_idle & ~flush;
    assign w_mul_done   = (r_state == S_MUL) & (r_cnt == LAT);
    assign w_hilo       = {r_hi, r_lo};

    assign stall_out  = rst & op_valid & w_valid_code & ~w_idle;
    assign mul_a      = op_a;
    assign mul_b      = op_b;
    assign div_a      = op_a;
    assign div_b      = op_b;
    assign mul_start  = w_accept & w_is_mul;
    assign mul_signed = ~op_code[0];
    // A zero divisor never reaches the divider; HI/LO are left as they were.
    assign div_start  = w_accept & w_is_div & (op_b != 32'd0);
    assign div_signed = ~op_code[0];
    assign div_abort  = rst & flush & (r_state == S_DIV);
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign busy       = ~w_idle;

    // MFHI/MFLO read port: only drives data for an accepted move-from.
    always_comb begin
        mf_data = 32'd0;
        if (w_accept && op_code == OP_MFHI)
            mf_data = r_hi;
        else if (w_accept && op_code == OP_MFLO)
            mf_data = r_lo;
    end

    // Next HI/LO value at multiply completion, wrapping modulo 2^64.
    always_comb begin
        w_hilo_next = mul_result;
        case (r_acc)
            ACC_ADD: w_hilo_next = w_hilo + mul_result;
            ACC_SUB: w_hilo_next = w_hilo - mul_result;
            default: w_hilo_next = mul_result;
        endcase
    end

    // Sequencer FSM and HI/LO state; flush beats completion in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_acc   <= ACC_NONE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= S_MUL;
                            r_cnt   <= 4'd1;
                            r_acc   <= !op_code[2] ? ACC_NONE :
                                       (op_code[1] ? ACC_SUB : ACC_ADD);
                        end else if (div_start) begin
                            r_state <= S_DIV;
                        end else if (op_code == OP_MTHI) begin
                            r_hi <= op_a;
                        end else if (op_code == OP_MTLO) begin
                            r_lo <= op_a;
                        end
                    end
                end
                S_MUL: begin
                    if (w_mul_done) begin
                        r_hi    <= w_hilo_next[63:32];
                        r_lo    <= w_hilo_next[31:0];
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        r_lo    <= div_quot;
                        r_hi    <= div_rem;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Bench for muldiv_scheduler: directed vector table plus randomized traffic
// against a transaction-level HI/LO model, with simple multiplier/divider devices.
module tb_muldiv_scheduler;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst, op_valid, flush, div_done;
    logic [3:0]  op_code;
    logic [31:0] op_a, op_b, div_quot, div_rem;
    logic [63:0] mul_result;
    logic        stall_out, mul_start, mul_signed, div_start, div_signed, div_abort, busy;
    logic [31:0] mf_data, mul_a, mul_b, div_a, div_b, hi, lo;

    always #5 clk = ~clk;

    muldiv_scheduler #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .flush(flush), .stall_out(stall_out),
        .mf_data(mf_data), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_signed(mul_signed), .mul_result(mul_result), .div_a(div_a),
        .div_b(div_b), .div_start(div_start), .div_signed(div_signed),
        .div_abort(div_abort), .div_done(div_done), .div_quot(div_quot),
        .div_rem(div_rem), .hi(hi), .lo(lo), .busy(busy)
    );

    typedef struct {
        bit          r, v, f, xd, ck, e_st, e_bz;
        logic [3:0]  c;
        logic [31:0] a, b, e_mf, e_hi, e_lo;
    } vec_t;

    vec_t        tab[$];
    int          n_cmp = 0, n_bad = 0;
    longint      cyc = 0;

    // device models (multiplier / divider the scheduler drives)
    longint      mul_due = -1, div_due = -1;
    logic [63:0] dev_prod;
    logic [31:0] dev_q, dev_r;
    bit          rnd_lat = 0;

    // reference model: HI/LO pair plus the one outstanding operation
    logic [63:0] m_hilo = 64'd0;
    int          m_pend = 0;       // 0 none, 1 multiply, 2 divide
    longint      m_due = 0;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    bit          m_known = 0;

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic signed [63:0] sa, sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] dq(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        if (sgn) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    function automatic logic [31:0] dr(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        if (sgn) return $signed(a) % $signed(b);
        return a % b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic row(input bit r, v, input logic [3:0] c, input logic [31:0] a, b,
                       input bit f, xd, ck, st, bz, input logic [31:0] mf, h, l);
        vec_t t;
        t.r = r; t.v = v; t.c = c; t.a = a; t.b = b; t.f = f; t.xd = xd;
        t.ck = ck; t.e_st = st; t.e_bz = bz; t.e_mf = mf; t.e_hi = h; t.e_lo = l;
        tab.push_back(t);
    endtask

    // Compare this cycle's outputs with the model, then advance model and devices.
    task automatic model_cycle();
        bit vc, acc, is_mul, is_div, bsy;
        logic [31:0] exp_mf;
        logic [63:0] p;
        vc     = (op_code < 4'd12);
        bsy    = (m_pend != 0);
        acc    = rst && op_valid && vc && !bsy && !flush;
        is_mul = op_code inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
        is_div = op_code inside {4'd2, 4'd3};
        exp_mf = (acc && op_code == 4'd10) ? m_hilo[63:32] :
                 (acc && op_code == 4'd11) ? m_hilo[31:0] : 32'd0;
        if (m_known) begin
            chk("busy", busy, bsy);
            chk("hi", hi, m_hilo[63:32]);
            chk("lo", lo, m_hilo[31:0]);
        end
        chk("stall_out", stall_out, rst && op_valid && vc && bsy);
        chk("mul_start", mul_start, acc && is_mul);
        chk("div_start", div_start, acc && is_div && op_b != 0);
        chk("div_abort", div_abort, rst && flush && m_pend == 2);
        chk("mf_data", mf_data, exp_mf);
        chk("operands", {mul_a, div_b}, {op_a, op_b});
        if (acc && is_mul) chk("mul_signed", mul_signed, !op_code[0]);
        if (acc && is_div && op_b != 0) chk("div_signed", div_signed, !op_code[0]);

        // devices react to the pulses they see
        if (mul_start) begin
            dev_prod = prod(op_a, op_b, mul_signed);
            mul_due  = cyc + MUL_LAT;
        end
        if (div_start && op_b != 0) begin
            dev_q   = dq(op_a, op_b, div_signed);
            dev_r   = dr(op_a, op_b, div_signed);
            div_due = cyc + (rnd_lat ? longint'($urandom_range(1, 12)) : 64'sd10);
        end
        if (div_abort) div_due = -1;

        // architectural effect of this edge
        if (!rst) begin
            m_hilo = 64'd0; m_pend = 0; m_known = 1;
        end else if (flush) begin
            m_pend = 0;
        end else begin
            if (m_pend == 1 && cyc == m_due) begin
                p = prod(m_a, m_b, !m_op[0]);
                if (m_op inside {4'd4, 4'd5})      m_hilo = m_hilo + p;
                else if (m_op inside {4'd6, 4'd7}) m_hilo = m_hilo - p;
                else                               m_hilo = p;
                m_pend = 0;
            end else if (m_pend == 2 && div_done) begin
                m_hilo = {dr(m_a, m_b, !m_op[0]), dq(m_a, m_b, !m_op[0])};
                m_pend = 0;
            end
            if (acc) begin
                m_op = op_code; m_a = op_a; m_b = op_b;
                if (is_mul) begin
                    m_pend = 1; m_due = cyc + MUL_LAT;
                end else if (is_div && op_b != 0) begin
                    m_pend = 2;
                end else if (op_code == 4'd8) begin
                    m_hilo[63:32] = op_a;
                end else if (op_code == 4'd9) begin
                    m_hilo[31:0] = op_a;
                end
            end
        end
    endtask

    task automatic step(input vec_t t);
        logic [31:0] g0, g1;
        g0 = $urandom; g1 = $urandom;
        rst = t.r; op_valid = t.v; op_code = t.c; op_a = t.a; op_b = t.b; flush = t.f;
        mul_result = (cyc == mul_due) ? dev_prod : {g0, g1};
        if (cyc == div_due) begin
            div_done = 1'b1; div_quot = dev_q; div_rem = dev_r;
        end else begin
            div_done = t.xd; div_quot = g1; div_rem = g0;
        end
        @(negedge clk);
        if (t.ck) begin
            chk("tab_stall", stall_out, t.e_st);
            chk("tab_busy", busy, t.e_bz);
            chk("tab_mf", mf_data, t.e_mf);
            chk("tab_hi", hi, t.e_hi);
            chk("tab_lo", lo, t.e_lo);
        end
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t t;
        rst = 0; op_valid = 0; op_code = 0; op_a = 0; op_b = 0; flush = 0;
        div_done = 0; div_quot = 0; div_rem = 0; mul_result = 0;

        // r  v  c   a             b             f  xd ck st bz mf            hi            lo
        row(0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0,            0,            0);
        row(0, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0,            0,            0);
        // signed multiply then dependent MFLO stalls for the latency
        row(1, 1, 0, 32'hFFFFFFFE, 3,            0, 0, 1, 0, 0, 0,            0,            0);
        for (int i = 0; i < 3; i++)
            row(1, 1, 11, 0,       0,            0, 0, 1, 1, 1, 0,            0,            0);
        row(1, 1, 11, 0,           0,            0, 0, 1, 0, 0, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA);
        row(1, 1, 10, 0,           0,            0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFA);
        // unsigned multiply; code 12 while busy never stalls
        row(1, 1, 1, 32'hFFFFFFFF, 2,            0, 0, 1, 0, 0, 0,            32'hFFFFFFFF, 32'hFFFFFFFA);
        row(1, 1, 12, 0,           0,            0, 0, 1, 0, 1, 0,            32'hFFFFFFFF, 32'hFFFFFFFA);
        for (int i = 0; i < 2; i++)
            row(1, 0, 0, 0,        0,            0, 0, 1, 0, 1, 0,            32'hFFFFFFFF, 32'hFFFFFFFA);
        // MTHI/MTLO then multiply-accumulate and multiply-subtract
        row(1, 1, 8, 5,            0,            0, 0, 1, 0, 0, 0,            1,            32'hFFFFFFFE);
        row(1, 1, 9, 7,            0,            0, 0, 1, 0, 0, 0,            5,            32'hFFFFFFFE);
        row(1, 1, 4, 2,            3,            0, 0, 1, 0, 0, 0,            5,            7);
        for (int i = 0; i < 3; i++)
            row(1, 0, 0, 0,        0,            0, 0, 1, 0, 1, 0,            5,            7);
        row(1, 1, 6, 1,            14,           0, 0, 1, 0, 0, 0,            5,            13);
        for (int i = 0; i < 3; i++)
            row(1, 0, 0, 0,        0,            0, 0, 1, 0, 1, 0,            5,            13);
        // signed divide, divider answers after 10 cycles
        row(1, 1, 2, 7,            32'hFFFFFFFE, 0, 0, 1, 0, 0, 0,            4,            32'hFFFFFFFF);
        for (int i = 0; i < 10; i++)
            row(1, 0, 0, 0,        0,            0, 0, 1, 0, 1, 0,            4,            32'hFFFFFFFF);
        row(1, 1, 3, 123,          0,            0, 0, 1, 0, 0, 0,            1,            32'hFFFFFFFD);
        row(1, 1, 11, 0,           0,            0, 0, 1, 0, 0, 32'hFFFFFFFD, 1,            32'hFFFFFFFD);
        // flush in the fourth divide cycle, then a stale div_done
        row(1, 1, 2, 100,          7,            0, 0, 1, 0, 0, 0,            1,            32'hFFFFFFFD);
        for (int i = 0; i < 3; i++)
            row(1, 0, 0, 0,        0,            0, 0, 1, 0, 1, 0,            1,            32'hFFFFFFFD);
        row(1, 0, 0, 0,            0,            1, 0, 1, 0, 1, 0,            1,            32'hFFFFFFFD);
        row(1, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0,            1,            32'hFFFFFFFD);
        row(1, 0, 0, 0,            0,            0, 1, 1, 0, 0, 0,            1,            32'hFFFFFFFD);
        // flush coincident with ops in IDLE: nothing starts, nothing written
        row(1, 1, 0, 3,            4,            1, 0, 1, 0, 0, 0,            1,            32'hFFFFFFFD);
        row(1, 1, 8, 32'hDEAD,     0,            1, 0, 1, 0, 0, 0,            1,            32'hFFFFFFFD);
        row(1, 1, 10, 0,           0,            0, 0, 1, 0, 0, 1,            1,            32'hFFFFFFFD);
        // reset in the middle of a multiply; product arrives afterwards
        row(1, 1, 8, 9,            0,            0, 0, 1, 0, 0, 0,            1,            32'hFFFFFFFD);
        row(1, 1, 0, 6,            7,            0, 0, 1, 0, 0, 0,            9,            32'hFFFFFFFD);
        row(1, 0, 0, 0,            0,            0, 0, 1, 0, 1, 0,            9,            32'hFFFFFFFD);
        row(0, 1, 11, 0,           0,            0, 0, 1, 0, 1, 0,            9,            32'hFFFFFFFD);
        row(1, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0,            0,            0);
        row(1, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0,            0,            0);

        foreach (tab[i]) step(tab[i]);

        // randomized traffic against the model
        rnd_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            t.r  = ($urandom % 64) != 0;
            t.v  = ($urandom % 3) != 0;
            t.c  = 4'($urandom % 16);
            t.a  = $urandom;
            t.b  = (($urandom % 8) == 0) ? 32'd0 : ((($urandom % 4) == 0) ? 32'($urandom % 16) : $urandom);
            if (t.a == 32'h80000000 && t.b == 32'hFFFFFFFF) t.b = 32'd1;
            t.f  = ($urandom % 20) == 0;
            t.xd = (m_pend != 2) && (($urandom % 6) == 0);
            t.ck = 0; t.e_st = 0; t.e_bz = 0; t.e_mf = 0; t.e_hi = 0; t.e_lo = 0;
            step(t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
